// File: rtl/fifo_rd_stream_pkg.sv
// ----------------------------------------------------------------------------
// fifo_rd_stream_pkg
// Shared types and constants for the FIFO read-side streaming adapter.
//   rdbuf_state_t      : occupancy state of the 2-entry output buffer
//   DEFAULT_DATA_WIDTH : FIFO/RAM word width shared with the FIFO instances
//   DEFAULT_CNT_WIDTH  : width of the delivered-word counter
//   occ_of()           : maps a buffer state to its entry count
// ----------------------------------------------------------------------------
package fifo_rd_stream_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } rdbuf_state_t;

    localparam int DEFAULT_DATA_WIDTH = 24;
    localparam int DEFAULT_CNT_WIDTH  = 16;

    function automatic logic [1:0] occ_of(input rdbuf_state_t s);
        logic [1:0] occ;
        case (s)
            EMPTY:   occ = 2'd0;
            ONE:     occ = 2'd1;
            TWO:     occ = 2'd2;
            default: occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/fifo_rd_stream_if.sv
// ----------------------------------------------------------------------------
// fifo_rd_stream_if
// Bundles the FIFO-side and consumer-side signals of the read adapter.
//   fifo_empty  : empty flag from the FIFO controller
//   fifo_rdata  : RAM read data, valid one cycle after fifo_rd
//   fifo_rd     : read strobe towards the FIFO controller
//   flush       : discard buffered and in-flight data
//   out_ready   : consumer can accept
//   out_valid   : out_data holds a word
//   out_data    : head word of the output buffer
//   xfer_count  : completed output transfers (wrapping)
// Modports: master = the adapter, slave = its environment.
// ----------------------------------------------------------------------------
interface fifo_rd_stream_if
    import fifo_rd_stream_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int CNT_WIDTH  = DEFAULT_CNT_WIDTH
);
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_rdata;
    logic                  fifo_rd;
    logic                  flush;
    logic                  out_ready;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic [CNT_WIDTH-1:0]  xfer_count;

    modport master (
        input  fifo_empty, fifo_rdata, flush, out_ready,
        output fifo_rd, out_valid, out_data, xfer_count
    );

    modport slave (
        output fifo_empty, fifo_rdata, flush, out_ready,
        input  fifo_rd, out_valid, out_data, xfer_count
    );
endinterface

// File: rtl/fifo_rd_stream_rd_skid_buf.sv
// ----------------------------------------------------------------------------
// rd_skid_buf
// Two-entry register buffer with push/pop, head output and occupancy state.
//   clk, reset    : clock, asynchronous active-high reset
//   push_i        : write push_data_i into the tail this edge
//   pop_i         : drop the head entry this edge (ignored when empty)
//   flush_i       : empty the buffer (data registers keep their contents)
//   push_data_i   : data to store on push
//   head_o        : current head entry; retains its last value when empty
//   state_o       : EMPTY / ONE / TWO
//   overflow_o    : push into a full buffer without a pop (must never occur)
// ----------------------------------------------------------------------------
module rd_skid_buf
    import fifo_rd_stream_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  logic                  flush_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    output logic [DATA_WIDTH-1:0] head_o,
    output rdbuf_state_t          state_o,
    output logic                  overflow_o
);

    rdbuf_state_t          state_q, state_d;
    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] tail_q, tail_d;

    always_comb begin
        state_d    = state_q;
        head_d     = head_q;
        tail_d     = tail_q;
        overflow_o = 1'b0;
        if (flush_i) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (push_i) begin
                        head_d  = push_data_i;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    case ({push_i, pop_i})
                        2'b10: begin
                            tail_d  = push_data_i;
                            state_d = TWO;
                        end
                        2'b01: state_d = EMPTY;   // head value is kept as out_data
                        2'b11: head_d  = push_data_i;
                        default: ;
                    endcase
                end
                TWO: begin
                    if (pop_i) begin
                        head_d = tail_q;
                        if (push_i) begin
                            tail_d = push_data_i;
                        end else begin
                            state_d = ONE;
                        end
                    end else if (push_i) begin
                        overflow_o = 1'b1;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    assign head_o  = head_q;
    assign state_o = state_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// ----------------------------------------------------------------------------
// fifo_rd_stream
// Read-side adapter: issues FIFO reads, captures RAM data one cycle later and
// presents it as a first-word-fall-through valid/ready stream.
//   clk    : system clock
//   reset  : asynchronous active-high reset
//   bus    : fifo_rd_stream_if.master (FIFO side + consumer side + counter)
// ----------------------------------------------------------------------------
module fifo_rd_stream
    import fifo_rd_stream_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int CNT_WIDTH  = DEFAULT_CNT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    fifo_rd_stream_if.master bus
);

    rdbuf_state_t          buf_state;
    logic [DATA_WIDTH-1:0] buf_head;
    logic                  buf_overflow;

    logic                  inflight_q;
    logic [CNT_WIDTH-1:0]  xfer_count_q, xfer_count_d;

    logic                  out_valid;
    logic                  pop;
    logic                  capture;
    logic                  fifo_rd;
    logic [2:0]            pending;

    always_comb begin
        out_valid = (buf_state != EMPTY) && !bus.flush;
        pop       = out_valid && bus.out_ready;
        capture   = inflight_q && !bus.flush;
        // Words that will be held or arriving after this edge without a new
        // read; a read is allowed only if that leaves room for its return.
        // pop implies occ >= 1, so the subtraction cannot underflow.
        pending   = {1'b0, occ_of(buf_state)} + {2'b00, inflight_q} - {2'b00, pop};
        // Never read while empty: the controller would still move pointers.
        fifo_rd   = !reset && !bus.flush && !bus.fifo_empty && (pending <= 3'd1);
        xfer_count_d = pop ? xfer_count_q + CNT_WIDTH'(1) : xfer_count_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inflight_q   <= 1'b0;
            xfer_count_q <= '0;
        end else begin
            inflight_q   <= fifo_rd;
            xfer_count_q <= xfer_count_d;
        end
    end

    rd_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk         (clk),
        .reset       (reset),
        .push_i      (capture),
        .pop_i       (pop),
        .flush_i     (bus.flush),
        .push_data_i (bus.fifo_rdata),
        .head_o      (buf_head),
        .state_o     (buf_state),
        .overflow_o  (buf_overflow)
    );

    assign bus.fifo_rd    = fifo_rd;
    assign bus.out_valid  = out_valid;
    assign bus.out_data   = buf_head;
    assign bus.xfer_count = xfer_count_q;

    // The issue rule keeps occupancy plus in-flight at most 2.
    a_no_overflow: assert property (@(posedge clk) disable iff (reset) !buf_overflow);

endmodule

// File: tb/tb_fifo_rd_stream.sv
// ----------------------------------------------------------------------------
// tb_fifo_rd_stream
// Randomized and directed stimulus for fifo_rd_stream against a queue-based
// reference model, plus literal checks for the directed scenarios.
// ----------------------------------------------------------------------------
module tb_fifo_rd_stream;
    localparam int DW   = 24;
    localparam int CW   = 16;
    localparam int MEMD = 256;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fifo_rd_stream_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

    fifo_rd_stream #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // FIFO environment: word storage with free-running read/write pointers.
    logic [DW-1:0] mem [MEMD];
    int            rptr = 0;
    int            wptr = 0;
    logic          hold_empty;

    assign bus.fifo_empty = hold_empty || (rptr == wptr);

    always @(posedge clk) begin
        if (bus.fifo_rd) begin
            bus.fifo_rdata <= mem[rptr % MEMD];
            rptr           <= rptr + 1;
        end
    end

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: buffered words, one possible in-flight word.
    logic [DW-1:0] m_buf [$];
    bit            m_infl      = 1'b0;
    logic [DW-1:0] m_infl_data = '0;
    logic [DW-1:0] m_head      = '0;
    int            m_rptr      = 0;
    logic [CW-1:0] m_cnt       = '0;

    int            rd_pulses  = 0;
    int            pops_total = 0;
    logic [DW-1:0] got [$];
    bit            verbose = 1'b1;

    always @(negedge clk) begin
        bit e_valid, e_pop, e_rd;
        int pend;
        if (reset) begin
            m_buf.delete();
            m_infl = 1'b0;
            m_cnt  = '0;
            m_head = '0;
        end
        e_valid = (m_buf.size() > 0) && !bus.flush && !reset;
        e_pop   = e_valid && bus.out_ready;
        pend    = m_buf.size() + int'(m_infl) - int'(e_pop);
        e_rd    = !reset && !bus.flush && !bus.fifo_empty && (pend <= 1);

        chk("fifo_rd",        32'(bus.fifo_rd),    32'(e_rd));
        chk("out_valid",      32'(bus.out_valid),  32'(e_valid));
        chk("out_data",       32'(bus.out_data),   32'(m_head));
        chk("xfer_count",     32'(bus.xfer_count), 32'(m_cnt));
        chk("rd_while_empty", 32'(bus.fifo_rd && bus.fifo_empty), 32'd0);

        if (bus.out_valid && bus.out_ready) begin
            got.push_back(bus.out_data);
            pops_total++;
            if (verbose) $display("xfer %0d data=%06h count=%0d", pops_total, bus.out_data, bus.xfer_count);
        end
        if (bus.fifo_rd) rd_pulses++;

        if (!reset) begin
            if (e_pop) begin
                void'(m_buf.pop_front());
                m_cnt = m_cnt + 1'b1;
            end
            if (m_infl && !bus.flush) m_buf.push_back(m_infl_data);
            if (bus.flush) m_buf.delete();
            m_infl = e_rd;
            if (e_rd) begin
                m_infl_data = mem[m_rptr % MEMD];
                m_rptr++;
            end
            if (m_buf.size() > 0) m_head = m_buf[0];
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [DW-1:0] w);
        mem[wptr % MEMD] = w;
        wptr++;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        bus.flush = 1'b0;
        bus.out_ready = 1'b0;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    task automatic preload4(input logic [DW-1:0] base);
        for (int k = 1; k <= 4; k++) push_word(DW'(base * k));
    endtask

    task automatic chk_got(input string name, input logic [DW-1:0] base, input int n);
        chk({name, "_count"}, 32'(got.size()), 32'(n));
        for (int k = 0; k < n; k++) begin
            if (k < got.size()) chk(name, 32'(got[k]), 32'(DW'(base * (k + 1))));
        end
    endtask

    initial begin
        reset         = 1'b1;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        hold_empty    = 1'b0;
        cyc();
        cyc();
        reset = 1'b0;

        // Idle: FIFO empty for 10 cycles.
        rd_pulses = 0;
        repeat (10) cyc();
        chk("idle_rd_pulses", 32'(rd_pulses), 32'd0);
        chk("idle_valid", 32'(bus.out_valid), 32'd0);
        chk("idle_count", 32'(bus.xfer_count), 32'd0);

        // Streaming with out_ready high.
        got.delete();
        rd_pulses     = 0;
        bus.out_ready = 1'b1;
        preload4(24'h000011);
        cyc();
        chk("latency_c1_valid", 32'(bus.out_valid), 32'd0);
        cyc();
        chk("latency_c2_valid", 32'(bus.out_valid), 32'd1);
        chk("latency_c2_data", 32'(bus.out_data), 32'h11);
        repeat (6) cyc();
        chk("stream_rd_pulses", 32'(rd_pulses), 32'd4);
        chk_got("stream_word", 24'h000011, 4);
        chk("stream_count", 32'(bus.xfer_count), 32'd4);

        // Back-pressure then release.
        do_reset();
        got.delete();
        rd_pulses = 0;
        preload4(24'h000011);
        repeat (8) cyc();
        chk("bp_rd_pulses", 32'(rd_pulses), 32'd2);
        chk("bp_valid", 32'(bus.out_valid), 32'd1);
        chk("bp_data_held", 32'(bus.out_data), 32'h11);
        bus.out_ready = 1'b1;
        repeat (8) cyc();
        chk_got("bp_word", 24'h000011, 4);

        // FIFO goes empty right after one read.
        do_reset();
        got.delete();
        rd_pulses     = 0;
        bus.out_ready = 1'b1;
        push_word(24'h000055);
        push_word(24'h000066);
        push_word(24'h000077);
        cyc();
        hold_empty = 1'b1;
        repeat (6) cyc();
        chk("empty_rd_pulses", 32'(rd_pulses), 32'd1);
        chk("empty_got_count", 32'(got.size()), 32'd1);
        if (got.size() > 0) chk("empty_word", 32'(got[0]), 32'h55);
        hold_empty = 1'b0;
        repeat (8) cyc();

        // Flush with one word buffered and one in flight.
        do_reset();
        got.delete();
        preload4(24'h0000A1);
        cyc();
        cyc();
        bus.flush = 1'b1;
        cyc();
        bus.flush = 1'b0;
        chk("flush_valid_after", 32'(bus.out_valid), 32'd0);
        bus.out_ready = 1'b1;
        repeat (6) cyc();
        chk("flush_got_count", 32'(got.size()), 32'd2);
        if (got.size() > 0) chk("flush_next_word", 32'(got[0]), 32'(24'h0000A1 * 3));

        // Randomized traffic with one asynchronous reset mid-stream.
        for (int i = 0; i < 2000; i++) begin
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.flush     = ($urandom_range(0, 19) == 0);
            hold_empty    = ($urandom_range(0, 7) == 0);
            if ((wptr - rptr) < 8 && $urandom_range(0, 1) == 1) push_word(DW'($urandom));
            if (i == 1000) begin
                #2;
                reset = 1'b1;
                #1;
                chk("async_rst_valid", 32'(bus.out_valid), 32'd0);
                chk("async_rst_rd", 32'(bus.fifo_rd), 32'd0);
                chk("async_rst_count", 32'(bus.xfer_count), 32'd0);
                cyc();
                reset = 1'b0;
            end else begin
                cyc();
            end
        end

        // Counter wrap after 65536 transfers.
        do_reset();
        verbose       = 1'b0;
        bus.flush     = 1'b0;
        hold_empty    = 1'b0;
        bus.out_ready = 1'b1;
        pops_total    = 0;
        for (int i = 0; i < 70000; i++) begin
            if (pops_total >= 65536) break;
            while ((wptr - rptr) < 16) push_word(DW'(wptr));
            cyc();
        end
        chk("wrap_pops", 32'(pops_total), 32'd65536);
        chk("wrap_count", 32'(bus.xfer_count), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
